// File: rtl/game_pkg.sv
// Shared screen codes and game-flow sequencer state encoding.
package game_pkg;

   // Router screen codes
   localparam logic [1:0] SCREEN_MENU     = 2'b00;
   localparam logic [1:0] SCREEN_PLAYING  = 2'b01;
   localparam logic [1:0] SCREEN_FINISHED = 2'b10;
   localparam logic [1:0] SCREEN_IDLE     = 2'b11;

   typedef enum logic [1:0] {
      ST_MENU      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_RACE      = 2'd2,
      ST_FINISHED  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/game_flow_sequencer_sec_tick_prescaler.sv
// One-second tick generator: counts 0..TICKS_PER_SEC-1 while enabled and
// strobes tick during the last count of each second.
module sec_tick_prescaler #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

   logic [W-1:0] cnt_q;

   // Wrap on LAST explicitly; the counter width may exceed the period.
   assign tick = enable && (cnt_q == LAST);

   // Counter held at zero when disabled or cleared, wraps after LAST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (clear || !enable || tick)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + W'(1);
   end

endmodule

// File: rtl/game_flow_sequencer.sv
// Game-flow sequencer: menu -> countdown -> race -> finished -> menu.
// All outputs are registered from the next-state decode so they change on
// the same edge as the state transition.
module game_flow_sequencer
   import game_pkg::*;
#(
   parameter int TICKS_PER_SEC   = 50_000_000,
   parameter int COUNTDOWN_SEC   = 3,
   parameter int FINISH_HOLD_SEC = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_btn,
   input  logic [1:0] current_screen,
   output logic       is_in_menu,
   output logic       race_enable,
   output logic       clear_positions,
   output logic       countdown_active,
   output logic [1:0] countdown_value
);

   if (COUNTDOWN_SEC < 1 || COUNTDOWN_SEC > 3) begin : g_bad_countdown
      $error("COUNTDOWN_SEC must be in 1..3");
   end
   if (FINISH_HOLD_SEC < 1 || FINISH_HOLD_SEC > 15) begin : g_bad_hold
      $error("FINISH_HOLD_SEC must be in 1..15");
   end

   localparam logic [1:0] CD_INIT   = 2'(COUNTDOWN_SEC);
   localparam logic [3:0] HOLD_LAST = 4'(FINISH_HOLD_SEC - 1);

   seq_state_t state_q, state_d;
   logic       start_q, start_edge;
   logic       sec_tick, presc_en, presc_clr;
   logic [3:0] hold_q, hold_d;
   logic [1:0] cd_val_d;
   logic       clear_d;

   // start_q resets high so a button held through reset is not an edge
   assign start_edge = start_btn & ~start_q;
   assign presc_en   = (state_q == ST_COUNTDOWN) || (state_q == ST_FINISHED);

   sec_tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (presc_en),
      .clear  (presc_clr),
      .tick   (sec_tick)
   );

   // Next-state and next-output decode
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      cd_val_d  = countdown_value;
      clear_d   = 1'b0;
      presc_clr = 1'b0;
      case (state_q)
         ST_MENU: begin
            if (start_edge) begin
               state_d   = ST_COUNTDOWN;
               cd_val_d  = CD_INIT;
               clear_d   = 1'b1;
               presc_clr = 1'b1;
            end
         end
         ST_COUNTDOWN: begin
            if (sec_tick) begin
               if (countdown_value == 2'd1) begin
                  state_d  = ST_RACE;
                  cd_val_d = 2'd0;
               end else begin
                  cd_val_d = countdown_value - 2'd1;
               end
            end
         end
         ST_RACE: begin
            if (current_screen == SCREEN_FINISHED) begin
               state_d   = ST_FINISHED;
               hold_d    = 4'd0;
               presc_clr = 1'b1;
            end
         end
         ST_FINISHED: begin
            // Start and hold expiry together still land in MENU only
            if (start_edge || (sec_tick && hold_q == HOLD_LAST)) begin
               state_d = ST_MENU;
               hold_d  = 4'd0;
            end else if (sec_tick) begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: state_d = ST_MENU;
      endcase
   end

   // State, edge detector, hold counter and registered Moore outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_MENU;
         start_q          <= 1'b1;
         hold_q           <= 4'd0;
         is_in_menu       <= 1'b1;
         race_enable      <= 1'b0;
         clear_positions  <= 1'b0;
         countdown_active <= 1'b0;
         countdown_value  <= 2'd0;
      end else begin
         state_q          <= state_d;
         start_q          <= start_btn;
         hold_q           <= hold_d;
         is_in_menu       <= (state_d == ST_MENU);
         race_enable      <= (state_d == ST_RACE);
         clear_positions  <= clear_d;
         countdown_active <= (state_d == ST_COUNTDOWN);
         countdown_value  <= cd_val_d;
      end
   end

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Directed bench for game_flow_sequencer (4 ticks/s, 3 s countdown, 2 s hold).
module tb_game_flow_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_btn;
   logic [1:0] current_screen;
   logic       is_in_menu, race_enable, clear_positions, countdown_active;
   logic [1:0] countdown_value;

   int pass_cnt  = 0;
   int total_cnt = 0;

   game_flow_sequencer #(
      .TICKS_PER_SEC   (4),
      .COUNTDOWN_SEC   (3),
      .FINISH_HOLD_SEC (2)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_btn        (start_btn),
      .current_screen   (current_screen),
      .is_in_menu       (is_in_menu),
      .race_enable      (race_enable),
      .clear_positions  (clear_positions),
      .countdown_active (countdown_active),
      .countdown_value  (countdown_value)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag, input logic menu, input logic race,
                          input logic clr, input logic act, input logic [1:0] val);
      chk({tag, ".menu"}, is_in_menu, menu);
      chk({tag, ".race"}, race_enable, race);
      chk({tag, ".clr"},  clear_positions, clr);
      chk({tag, ".act"},  countdown_active, act);
      chk({tag, ".val"},  countdown_value, val);
   endtask

   initial begin
      rst_n = 1'b0; start_btn = 1'b0; current_screen = 2'b11;
      #13;
      chk_all("in_reset", 1, 0, 0, 0, 2'd0);
      step(1);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk_all("idle", 1, 0, 0, 0, 2'd0);
      end

      // Start edge -> countdown 3,2,1 four cycles each, race at edge 12
      start_btn = 1'b1;
      step(1);
      chk_all("cd_entry", 0, 0, 1, 1, 2'd3);
      start_btn = 1'b0;
      for (int k = 1; k < 12; k++) begin
         step(1);
         chk_all("cd_run", 0, 0, 0, 1, 2'(3 - k / 4));
         if (k == 5) start_btn = 1'b1;   // edge during countdown is ignored
         if (k == 8) start_btn = 1'b0;
      end
      step(1);
      chk_all("race_entry", 0, 1, 0, 0, 2'd0);

      // Race: start edge and codes 01/00/11 keep RACE
      start_btn = 1'b1; current_screen = 2'b01;
      step(20);
      chk_all("race_01", 0, 1, 0, 0, 2'd0);
      current_screen = 2'b00;
      step(2);
      chk("race_00", race_enable, 1);
      current_screen = 2'b11;
      step(2);
      chk("race_11", race_enable, 1);
      start_btn = 1'b0; current_screen = 2'b10;
      step(1);
      chk_all("fin_entry", 0, 0, 0, 0, 2'd0);
      current_screen = 2'b11;
      step(7);
      chk("fin_hold7", is_in_menu, 0);
      step(1);
      chk_all("fin_expire", 1, 0, 0, 0, 2'd0);

      // Early exit from FINISHED by start edge at hold cycle 2
      start_btn = 1'b1;
      step(1);
      chk("g2_start.act", countdown_active, 1);
      start_btn = 1'b0;
      step(12);
      chk("g2_race", race_enable, 1);
      current_screen = 2'b10;
      step(1);
      chk("g2_fin", race_enable, 0);
      current_screen = 2'b11;
      step(2);
      start_btn = 1'b1;
      step(1);
      chk_all("fin_start", 1, 0, 0, 0, 2'd0);
      step(3);
      chk_all("menu_held", 1, 0, 0, 0, 2'd0);
      start_btn = 1'b0;
      step(1);
      start_btn = 1'b1;
      step(1);
      chk_all("fresh_start", 0, 0, 1, 1, 2'd3);

      // Start edge coinciding with hold expiry -> MENU only
      start_btn = 1'b0;
      step(12);
      chk("g3_race", race_enable, 1);
      current_screen = 2'b10;
      step(1);
      current_screen = 2'b11;
      step(7);
      chk("g3_hold7", is_in_menu, 0);
      start_btn = 1'b1;
      step(1);
      chk_all("coincide", 1, 0, 0, 0, 2'd0);
      step(1);
      chk_all("coincide_after", 1, 0, 0, 0, 2'd0);
      start_btn = 1'b0;
      step(1);

      // Reset mid-countdown, button held across reset release
      start_btn = 1'b1;
      step(1);
      chk("g4_cd3", countdown_value, 3);
      step(4);
      chk("g4_cd2", countdown_value, 2);
      #2 rst_n = 1'b0;
      #1 chk_all("rst_mid_cd", 1, 0, 0, 0, 2'd0);
      step(2);
      rst_n = 1'b1;
      step(3);
      chk_all("held_thru_rst", 1, 0, 0, 0, 2'd0);
      start_btn = 1'b0;
      step(1);
      start_btn = 1'b1;
      step(1);
      chk_all("repress", 0, 0, 1, 1, 2'd3);
      start_btn = 1'b0;
      step(11);
      chk_all("cd_edge11", 0, 0, 0, 1, 2'd1);
      step(1);
      chk("cd_edge12", race_enable, 1);

      // Reset mid-race, then full 12-edge countdown again
      step(5);
      #2 rst_n = 1'b0;
      #1 chk_all("rst_mid_race", 1, 0, 0, 0, 2'd0);
      step(1);
      rst_n = 1'b1;
      step(2);
      chk("post_rst_menu", is_in_menu, 1);
      start_btn = 1'b1;
      step(1);
      chk("g6_act", countdown_active, 1);
      start_btn = 1'b0;
      step(11);
      chk("g6_edge11", race_enable, 0);
      step(1);
      chk_all("g6_edge12", 0, 1, 0, 0, 2'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/game_flow_sequencer.md
Name: game_flow_sequencer

Overview:
Top-level game-flow controller that sequences the screen router through menu, countdown, race and finish phases. It drives `is_in_menu` into the router and consumes the router's `current_screen` code to detect the end of a race. It also gates player movement (`race_enable`), requests a position clear at race start, and times the countdown and finish-hold phases from a one-second prescaler.

Parameters:
- TICKS_PER_SEC, 50_000_000: clock cycles per one-second tick (benches use 4).
- COUNTDOWN_SEC, 3: countdown length in seconds; legal range 1..3.
- FINISH_HOLD_SEC, 10: seconds the finish screen is held before auto-return to menu; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_btn  in  1  debounced, clk-synchronous start button level.
- current_screen  in  2  router output: 00 menu, 01 in progress, 10 finished, 11 idle/not started.
- is_in_menu  out  1  menu request to the router.
- race_enable  out  1  high while players may move.
- clear_positions  out  1  one-cycle pulse; position counters reset to 0.
- countdown_active  out  1  high during the countdown phase.
- countdown_value  out  2  seconds remaining in the countdown (3..1); 0 outside countdown.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on clk/rst_n.
- Reset values (applied immediately on rst_n low, including mid-race):
  - state=MENU, is_in_menu=1, race_enable=0, clear_positions=0.
  - countdown_active=0, countdown_value=0.
  - prescaler=0, hold counter=0, start_q=1.
- start_q reset to 1: a button held through reset release does NOT start a game.
- Start edge = start_btn & ~start_q; start_q is registered every cycle.
- All outputs are registered (Moore style) and change on the clock edge that performs the state transition.
- States MENU, COUNTDOWN, RACE, FINISHED; 2-bit encoding.
- MENU:
  - is_in_menu=1.
  - On start edge -> COUNTDOWN: is_in_menu=0, clear_positions=1 for exactly that one cycle, countdown_active=1, countdown_value=COUNTDOWN_SEC, prescaler cleared.
- COUNTDOWN:
  - The prescaler counts 0..TICKS_PER_SEC-1 and strobes on wrap.
  - On each strobe, countdown_value decrements.
  - On the strobe where countdown_value==1 -> RACE: race_enable=1, countdown_active=0, countdown_value=0.
  - race_enable rises exactly COUNTDOWN_SEC*TICKS_PER_SEC edges after COUNTDOWN entry.
  - Start edges are ignored.
  - current_screen is ignored (it reads 11 here).
- RACE:
  - race_enable=1.
  - When current_screen==10 is sampled -> FINISHED; race_enable=0 on that same edge, and the prescaler and hold counter are cleared.
  - Start edges are ignored.
  - Codes 00, 01 and 11 keep the block in RACE.
- FINISHED:
  - race_enable=0, is_in_menu=0.
  - The hold counter counts seconds.
  - On the strobe where hold==FINISH_HOLD_SEC-1 -> MENU (is_in_menu=1).
  - A start edge also -> MENU immediately.
  - If a start edge and hold expiry occur in the same cycle: a single transition to MENU; never directly to COUNTDOWN. A new game needs a fresh start edge in MENU.
- Widths:
  - Prescaler width = $clog2(TICKS_PER_SEC); it wraps at TICKS_PER_SEC-1, never at the power of two.
  - Hold counter is 4 bits.
  - countdown_value is 2 bits; COUNTDOWN_SEC=0 or >3 is illegal (elaboration-time check).
- Prescaler runs only in COUNTDOWN and FINISHED; it is held at 0 in MENU and RACE.

Decomposition:
- Shared package game_pkg holds:
  - screen codes SCREEN_MENU=2'b00, SCREEN_PLAYING=2'b01, SCREEN_FINISHED=2'b10, SCREEN_IDLE=2'b11 (also used by the router);
  - the sequencer state encoding.
- One natural sub-module: sec_tick_prescaler.
  - Parameter TICKS_PER_SEC.
  - Inputs clk, rst_n, enable, clear.
  - Output one-cycle tick strobe.

Test Plan (TICKS_PER_SEC=4, COUNTDOWN_SEC=3, FINISH_HOLD_SEC=2):
- Reset, then 10 idle cycles -> is_in_menu=1, race_enable=0, clear_positions=0, countdown_value=0 throughout.
- start_btn 0->1 in MENU -> next edge: is_in_menu=0, clear_positions=1 for exactly 1 cycle; countdown_value 3,2,1 for 4 cycles each; race_enable=1 exactly 12 edges after COUNTDOWN entry.
- In RACE, drive current_screen=01 for 20 cycles, then 10 -> race_enable=0 one edge later; after 8 further cycles is_in_menu=1 with no start input.
- In FINISHED, start edge at hold cycle 2 -> MENU next edge; clear_positions stays 0; a second start edge is required to enter COUNTDOWN.
- start_btn held high across rst_n release -> stays in MENU; release then re-press -> COUNTDOWN entered.
- Assert rst_n low mid-COUNTDOWN (countdown_value=2) and separately mid-RACE -> outputs return to reset values immediately; the next start yields a full 12-cycle countdown.
